// File: rtl/mpd_cfg_status.sv
// Configuration status tracker: DONE/LOADING FSM, heartbeat LED and stretched receive LED.
// Define MPD_CFG_STATUS_WDT_EN to add the LOADING inactivity watchdog and the ERROR state.
module mpd_cfg_status #(
  parameter int PRESCALE_W    = 20,
  parameter int MATCH_CYCLES  = 16,
  parameter int RXLED_STRETCH = 65535,
  parameter int WDT_TICKS     = 64
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       magic_match,
  input  logic       done_override,
  input  logic       rx_active,
  input  logic       rx_pulse,
  output logic       fabric_done,
  output logic       heart_led,
  output logic       rxled_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [7:0]  MATCH_LAST = 8'(MATCH_CYCLES - 1);
  localparam logic [15:0] STRETCH_LD = 16'(RXLED_STRETCH);

  if (MATCH_CYCLES < 1 || MATCH_CYCLES > 255) begin : g_bad_match
    $error("mpd_cfg_status: MATCH_CYCLES must be 1..255");
  end
  if (RXLED_STRETCH < 1 || RXLED_STRETCH > 65535) begin : g_bad_stretch
    $error("mpd_cfg_status: RXLED_STRETCH must be 1..65535");
  end
  if (WDT_TICKS < 1 || WDT_TICKS > 255) begin : g_bad_wdt
    $error("mpd_cfg_status: WDT_TICKS must be 1..255");
  end

  state_t                state, state_nx;
  logic                  match_q1, match_s;
  logic                  ovr_q1, ovr_s;
  logic                  rx_d;
  logic [PRESCALE_W-1:0] prescaler;
  logic [2:0]            phase;
  logic [7:0]            match_cnt;
  logic [15:0]           stretch_cnt;
  logic                  tick, rx_rise, done_cond, wdt_expired, heart_nx;

  assign tick      = &prescaler;
  assign rx_rise   = rx_active & ~rx_d;
  assign done_cond = ovr_s | (match_s & (match_cnt == MATCH_LAST));
  assign state_o   = state;

  // Synchronizers, edge detect and free-running counters run in every state.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      match_q1    <= 1'b0;
      match_s     <= 1'b0;
      ovr_q1      <= 1'b0;
      ovr_s       <= 1'b0;
      rx_d        <= 1'b0;
      prescaler   <= '0;
      phase       <= '0;
      match_cnt   <= '0;
      stretch_cnt <= '0;
    end else begin
      match_q1  <= magic_match;
      match_s   <= match_q1;
      ovr_q1    <= done_override;
      ovr_s     <= ovr_q1;
      rx_d      <= rx_active;
      prescaler <= prescaler + 1'b1;
      if (tick) phase <= phase + 3'd1;
      if (!match_s)                 match_cnt <= '0;
      else if (match_cnt != MATCH_LAST) match_cnt <= match_cnt + 8'd1;
      // A new strobe restarts the stretch rather than extending it.
      if (rx_pulse)                 stretch_cnt <= STRETCH_LD;
      else if (stretch_cnt != '0)   stretch_cnt <= stretch_cnt - 16'd1;
    end
  end

`ifdef MPD_CFG_STATUS_WDT_EN
  localparam logic [7:0] WDT_LIM = 8'(WDT_TICKS);
  logic [7:0] wdt_cnt;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                                 wdt_cnt <= '0;
    else if (state != ST_LOADING || rx_active)   wdt_cnt <= '0;
    else if (tick && wdt_cnt != WDT_LIM)         wdt_cnt <= wdt_cnt + 8'd1;
  end

  assign wdt_expired = (wdt_cnt == WDT_LIM);
`else
  assign wdt_expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (done_cond)      state_nx = ST_DONE;
        else if (rx_active) state_nx = ST_LOADING;
      end
      ST_LOADING: begin
        if (done_cond)        state_nx = ST_DONE;
        else if (wdt_expired) state_nx = ST_ERROR;
      end
      ST_DONE: begin
        // Override pins DONE; otherwise a new load or loss of match leaves it.
        if (!ovr_s && (rx_rise || !match_s)) state_nx = ST_LOADING;
      end
      ST_ERROR: begin
        if (done_cond)    state_nx = ST_DONE;
        else if (rx_rise) state_nx = ST_LOADING;
      end
    endcase
  end

  always_comb begin
    heart_nx = 1'b0;
    case (state)
      ST_IDLE:    heart_nx = (phase == 3'd0);
      ST_LOADING: heart_nx = phase[0];
      ST_DONE:    heart_nx = phase[2];
      ST_ERROR:   heart_nx = prescaler[PRESCALE_W-1];
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      fabric_done <= 1'b0;
      heart_led   <= 1'b0;
      rxled_o     <= 1'b0;
    end else begin
      fabric_done <= (state_nx == ST_DONE);
      heart_led   <= heart_nx;
      rxled_o     <= (stretch_cnt != '0);
    end
  end

endmodule

// File: tb/tb_mpd_cfg_status.sv
// Scoreboard bench for mpd_cfg_status: a per-edge reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_mpd_cfg_status;
  localparam int PW  = 4;
  localparam int MC  = 16;
  localparam int RX  = 200;
  localparam int WDT = 3;
`ifdef MPD_CFG_STATUS_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       CLK = 1'b0, resetn = 1'b0;
  logic       magic_match = 1'b0, done_override = 1'b0, rx_active = 1'b0, rx_pulse = 1'b0;
  logic       fabric_done, heart_led, rxled_o;
  logic [1:0] state_o;

  mpd_cfg_status #(.PRESCALE_W(PW), .MATCH_CYCLES(MC), .RXLED_STRETCH(RX), .WDT_TICKS(WDT)) dut (
    .CLK(CLK), .resetn(resetn), .magic_match(magic_match), .done_override(done_override),
    .rx_active(rx_active), .rx_pulse(rx_pulse), .fabric_done(fabric_done),
    .heart_led(heart_led), .rxled_o(rxled_o), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct { int st; bit fd; bit hb; bit led; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as an int 0..3, streaks and "cycles since pulse" instead of counters.
  int m_st, streak, since, presc, phase, idle_ticks;
  bit m1, ms, o1, os, rxp;

  task automatic mreset();
    m_st = 0; streak = 0; since = RX; presc = 0; phase = 0; idle_ticks = 0;
    m1 = 0; ms = 0; o1 = 0; os = 0; rxp = 0;
    q.delete();
  endtask

  task automatic mstep();
    int nst; bit tick, done, rise; exp_t e;
    tick = (presc == (1 << PW) - 1);
    done = os || (ms && streak >= MC - 1);
    rise = rx_active && !rxp;
    nst = m_st;
    case (m_st)
      0: if (done) nst = 2; else if (rx_active) nst = 1;
      1: if (done) nst = 2; else if (WDT_ON && idle_ticks >= WDT) nst = 3;
      2: if (!os && (rise || !ms)) nst = 1;
      default: if (done) nst = 2; else if (rise) nst = 1;
    endcase
    e.st  = nst;
    e.fd  = (nst == 2);
    case (m_st)
      0: e.hb = (phase == 0);
      1: e.hb = phase[0];
      2: e.hb = phase[2];
      default: e.hb = presc[PW-1];
    endcase
    e.led = (since < RX);
    if (m_st != 1 || rx_active) idle_ticks = 0;
    else if (tick && idle_ticks < WDT) idle_ticks++;
    streak = ms ? ((streak < 1000) ? streak + 1 : streak) : 0;
    since  = rx_pulse ? 0 : ((since < RX) ? since + 1 : since);
    if (tick) phase = (phase + 1) % 8;
    presc = (presc + 1) % (1 << PW);
    ms = m1; m1 = magic_match;
    os = o1; o1 = done_override;
    rxp = rx_active;
    m_st = nst;
    q.push_back(e);
  endtask

  always @(posedge CLK or negedge resetn) begin
    if (!resetn) mreset();
    else         mstep();
  end

  always @(negedge CLK) begin
    if (resetn && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state_o", state_o, e.st);
      chk("fabric_done", fabric_done, e.fd);
      chk("heart_led", heart_led, e.hb);
      chk("rxled_o", rxled_o, e.led);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_done"}, fabric_done, 0);
    chk({tag, "_heart"}, heart_led, 0);
    chk({tag, "_rxled"}, rxled_o, 0);
  endtask

  initial begin
    int n, hi;
    step(3);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Held match: fabric_done 17 edges after the first sampling edge.
    step(2);
    magic_match = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); n++;
      @(negedge CLK);
      if (fabric_done) break;
    end
    #1;
    chk("match_latency_edges", n - 1, 17);
    chk("match_state_done", state_o, 2);

    // Drop match (DONE -> LOADING), then a one-cycle glitch restarts the count.
    magic_match = 1'b0; step(5);
    magic_match = 1'b1; step(10);
    magic_match = 1'b0; step(1);
    magic_match = 1'b1; step(25);

    // Override while in DONE with match gone: DONE held, then LOADING.
    magic_match = 1'b0; done_override = 1'b1; step(3);
    done_override = 1'b0; step(8);

    // Two strobes 100 cycles apart: 300 cycles of LED.
    hi = 0;
    for (int t = 0; t < 320; t++) begin
      rx_pulse = (t == 0 || t == 100);
      @(negedge CLK);
      if (rxled_o) hi++;
      #1;
    end
    rx_pulse = 1'b0;
    chk("rxled_high_cycles", hi, 300);

    // Watchdog exercise (only reaches ERROR when the watchdog is built in).
    rx_active = 1'b1; step(4);
    rx_active = 1'b0; step(120);
    rx_active = 1'b1; step(3);
    rx_active = 1'b0; step(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) magic_match   = ~magic_match;
      if ($urandom_range(79) == 0) done_override = ~done_override;
      if ($urandom_range(14) == 0) rx_active     = ~rx_active;
      rx_pulse = ($urandom_range(49) == 0);
      step(1);
    end
    magic_match = 1'b0; done_override = 1'b0; rx_active = 1'b0; rx_pulse = 1'b0;
    step(5);

    // Asynchronous reset mid-stretch while in DONE.
    done_override = 1'b1; step(6);
    rx_pulse = 1'b1; step(1);
    rx_pulse = 1'b0; step(20);
    chk("pre_reset_done", fabric_done, 1);
    chk("pre_reset_rxled", rxled_o, 1);
    @(negedge CLK); #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    done_override = 1'b0;
    step(3);
    resetn = 1'b1;
    magic_match = 1'b1; step(30);
    chk("resume_done", fabric_done, 1);
    magic_match = 1'b0; step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
